// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Used by the receive, transmit and FIFO blocks.
package uart_pkg;

  localparam int UART_DATA_W   = 8;
  localparam int RX_FIFO_DEPTH = 16;

endpackage

// File: rtl/uart_fifo_mem.sv
// Byte register array for UART FIFOs.
// Synchronous write port, asynchronous read port.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = RX_FIFO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [UART_DATA_W-1:0] wdata,
  input  logic [AW-1:0]          raddr,
  output logic [UART_DATA_W-1:0] rdata
);

  logic [UART_DATA_W-1:0] mem [DEPTH];

  // Write port; contents are never reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO with level/error interrupt.
// Sits between the deserializer and the CSR block.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = RX_FIFO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   rx_valid,
  input  logic [UART_DATA_W-1:0] rx_byte,
  input  logic                   rx_frame_err,
  input  logic                   read,
  input  logic                   clr_err,
  input  logic                   irq_en,
  input  logic [AW:0]            threshold,
  output logic [UART_DATA_W-1:0] rd_data,
  output logic [AW:0]            level,
  output logic                   empty,
  output logic                   full,
  output logic                   overrun,
  output logic                   frame_err,
  output logic                   irq
);

  logic [AW:0]            wr_ptr;
  logic [AW:0]            rd_ptr;
  logic                   push_ok;
  logic                   pop_ok;
  logic                   ov_set;
  logic                   fe_set;
  logic                   ov_next;
  logic                   fe_next;
  logic [AW:0]            lvl_next;
  logic [AW:0]            thr_eff;
  logic                   irq_next;
  logic [UART_DATA_W-1:0] mem_rdata;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A full FIFO still accepts a byte when a pop frees a slot.
  always_comb begin
    pop_ok   = read & ~empty;
    push_ok  = rx_valid & (~full | read);
    ov_set   = rx_valid & full & ~read;
    fe_set   = rx_valid & rx_frame_err;
    ov_next  = ov_set | (overrun & ~clr_err);
    fe_next  = fe_set | (frame_err & ~clr_err);
    lvl_next = level + {{AW{1'b0}}, push_ok}
                     - {{AW{1'b0}}, pop_ok};
    thr_eff  = (threshold == '0) ?
               {{AW{1'b0}}, 1'b1} : threshold;
    irq_next = irq_en & ((lvl_next >= thr_eff) |
                         ov_next | fe_next);
  end

  // Pointers, level, sticky flags and irq.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      irq       <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      level     <= lvl_next;
      overrun   <= ov_next;
      frame_err <= fe_next;
      irq       <= irq_next;
    end
  end

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (wb_clk_i),
    .we    (push_ok & ~wb_rst_i),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (rx_byte),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (mem_rdata)
  );

  assign rd_data = empty ? '0 : mem_rdata;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo (DEPTH = 16).
// Directed steps plus random traffic vs a queue model.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_valid;
  logic [7:0]    rx_byte;
  logic          rx_frame_err;
  logic          read;
  logic          clr_err;
  logic          irq_en;
  logic [AW:0]   threshold;
  logic [7:0]    rd_data;
  logic [AW:0]   level;
  logic          empty;
  logic          full;
  logic          overrun;
  logic          frame_err;
  logic          irq;

  int passed = 0;
  int total  = 0;

  logic [7:0] q[$];
  logic       m_ov;
  logic       m_fe;
  logic       m_irq;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .rx_valid     (rx_valid),
    .rx_byte      (rx_byte),
    .rx_frame_err (rx_frame_err),
    .read         (read),
    .clr_err      (clr_err),
    .irq_en       (irq_en),
    .threshold    (threshold),
    .rd_data      (rd_data),
    .level        (level),
    .empty        (empty),
    .full         (full),
    .overrun      (overrun),
    .frame_err    (frame_err),
    .irq          (irq)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h",
                tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    logic [7:0] head;
    head = (q.size() > 0) ? q[0] : 8'h00;
    chk({tag, ".level"}, 32'(level), 32'(q.size()));
    chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
    chk({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
    chk({tag, ".rd_data"}, 32'(rd_data), 32'(head));
    chk({tag, ".overrun"}, 32'(overrun), 32'(m_ov));
    chk({tag, ".frame_err"}, 32'(frame_err), 32'(m_fe));
    chk({tag, ".irq"}, 32'(irq), 32'(m_irq));
  endtask

  // Drive one cycle, update the model, check after the edge.
  task automatic step(input logic r, input logic v,
                      input logic [7:0] b, input logic fe,
                      input logic rd, input logic clr,
                      input string tag);
    bit pop_ok;
    bit ovs;
    int thr;
    rst = r; rx_valid = v; rx_byte = b;
    rx_frame_err = fe; read = rd; clr_err = clr;
    if (r) begin
      q.delete();
      m_ov = 0; m_fe = 0; m_irq = 0;
    end else begin
      pop_ok = rd && q.size() > 0;
      ovs = 0;
      if (pop_ok) void'(q.pop_front());
      if (v) begin
        if (q.size() < DEPTH) q.push_back(b);
        else ovs = 1;
      end
      m_ov = ovs || (m_ov && !clr);
      m_fe = (v && fe) || (m_fe && !clr);
      thr = (threshold == 0) ? 1 : int'(threshold);
      m_irq = irq_en && (q.size() >= thr || m_ov || m_fe);
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic push(input logic [7:0] b, input string tag);
    step(0, 1, b, 0, 0, 0, tag);
  endtask

  task automatic pop(input string tag);
    step(0, 0, 8'h00, 0, 1, 0, tag);
  endtask

  task automatic idle(input string tag);
    step(0, 0, 8'h00, 0, 0, 0, tag);
  endtask

  initial begin
    rst = 1; rx_valid = 0; rx_byte = 0; rx_frame_err = 0;
    read = 0; clr_err = 0; irq_en = 0; threshold = 0;
    m_ov = 0; m_fe = 0; m_irq = 0;
    @(negedge clk);

    // 1: reset state, single push/pop
    step(1, 0, 8'h00, 0, 0, 0, "reset");
    chk("reset.level_const", 32'(level), 0);
    push(8'hA5, "t1.push");
    chk("t1.rd_A5", 32'(rd_data), 32'h A5);
    pop("t1.pop");
    chk("t1.rd_zero", 32'(rd_data), 0);
    pop("t1.pop_empty");

    // 2: fill, overrun, drain in order
    for (int i = 0; i < 16; i++) push(8'(i), "t2.fill");
    chk("t2.full", 32'(full), 1);
    push(8'hFF, "t2.ovr");
    chk("t2.ovr_flag", 32'(overrun), 1);
    chk("t2.ovr_level", 32'(level), 16);
    step(0, 1, 8'hEE, 0, 1, 0, "t2.full_pushpop");
    for (int i = 0; i < 16; i++) pop("t2.drain");
    step(0, 0, 8'h00, 0, 0, 1, "t2.clr");

    // 3: steady level 5 across pointer wrap
    for (int i = 0; i < 5; i++) push(8'($urandom), "t3.pre");
    for (int i = 0; i < 40; i++)
      step(0, 1, 8'($urandom), 0, 1, 0, "t3.pp");
    chk("t3.level5", 32'(level), 5);
    for (int i = 0; i < 5; i++) pop("t3.drain");
    step(0, 1, 8'h5A, 0, 1, 0, "t3.empty_pp");
    pop("t3.last");

    // 4: level interrupt
    irq_en = 1; threshold = 5'd4;
    for (int i = 0; i < 3; i++) push(8'(i), "t4.below");
    chk("t4.irq_low", 32'(irq), 0);
    push(8'h33, "t4.at");
    chk("t4.irq_high", 32'(irq), 1);
    pop("t4.drop");
    for (int i = 0; i < 3; i++) pop("t4.drain");
    threshold = 5'd0;
    push(8'h44, "t4.thr0");
    chk("t4.thr0_irq", 32'(irq), 1);
    threshold = 5'd20;
    idle("t4.thr_big");
    pop("t4.empty");

    // 5: frame error flag and clear
    step(0, 1, 8'h66, 1, 1, 0, "t5.fe");
    chk("t5.fe_flag", 32'(frame_err), 1);
    pop("t5.pop");
    step(0, 1, 8'h77, 1, 1, 1, "t5.clr_vs_set");
    chk("t5.fe_kept", 32'(frame_err), 1);
    step(0, 0, 8'h00, 0, 1, 1, "t5.clr");
    chk("t5.irq_gone", 32'(irq), 0);
    irq_en = 0;
    idle("t5.irq_off");

    // 6: reset mid-operation
    for (int i = 0; i < 8; i++) push(8'(8'h80 + i), "t6.fill");
    step(0, 1, 8'h99, 1, 0, 0, "t6.fe");
    step(1, 1, 8'hDD, 1, 1, 0, "t6.rst");
    chk("t6.empty", 32'(empty), 1);
    push(8'h3C, "t6.push");
    chk("t6.rd_3C", 32'(rd_data), 32'h3C);
    pop("t6.pop");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        irq_en = 1'($urandom);
        threshold = 5'($urandom_range(0, 20));
      end
      step(($urandom_range(0, 199) == 0),
           1'($urandom),
           8'($urandom),
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 20) == 0),
           "rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
